// File: rtl/frame_reader.sv
// frame_reader: XGA raster timing generator and windowed frame-buffer reader.
// Emits rgb_out, in_frame and the matching hcount/vcount/syncs, all aligned to the
// same pixel, MEM_LAT+2 clocks after the internal raster counters.
// Optional build macro FRAME_READER_PATTERN_EN adds a 'pattern' input that replaces
// in-window memory data with 8 vertical colour bars.
module frame_reader #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29,
    parameter int unsigned WIN_X    = 0,
    parameter int unsigned WIN_Y    = 0,
    parameter int unsigned WIN_W    = 640,
    parameter int unsigned WIN_H    = 480,
    parameter int unsigned MEM_LAT  = 2,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              reset,
`ifdef FRAME_READER_PATTERN_EN
    input  logic              pattern,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [23:0]       mem_data,
    output logic [10:0]       hcount,
    output logic [9:0]        vcount,
    output logic              hsync,
    output logic              vsync,
    output logic              blank,
    output logic              in_frame,
    output logic [23:0]       rgb_out,
    output logic              frame_start
);

    localparam int unsigned HC_W     = 11;
    localparam int unsigned VC_W     = 10;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DEPTH    = MEM_LAT + 1;

    // Per-pixel timing payload carried down the alignment delay line
    typedef struct packed {
        logic [HC_W-1:0] hcount;
        logic [VC_W-1:0] vcount;
        logic            hsync;
        logic            vsync;
        logic            blank;
        logic            win;
        logic            fstart;
        logic            pat;
        logic [23:0]     bar_rgb;
    } pix_t;

    localparam pix_t PIX_IDLE = '{hcount: 11'd0, vcount: 10'd0, hsync: 1'b1, vsync: 1'b1,
                                  blank: 1'b1, win: 1'b0, fstart: 1'b0, pat: 1'b0,
                                  bar_rgb: 24'd0};

    // Reject window geometries that cannot be displayed or addressed
    if (WIN_X + WIN_W > H_ACTIVE) begin : g_chk_x
        $error("frame_reader: window exceeds active width");
    end
    if (WIN_Y + WIN_H > V_ACTIVE) begin : g_chk_y
        $error("frame_reader: window exceeds active height");
    end
    if (64'(WIN_W) * 64'(WIN_H) > (64'd1 << ADDR_W)) begin : g_chk_a
        $error("frame_reader: window does not fit the address space");
    end
    if (MEM_LAT < 1) begin : g_chk_lat
        $error("frame_reader: MEM_LAT must be at least 1");
    end

    logic [HC_W-1:0]   hc;
    logic [VC_W-1:0]   vc;
    logic [ADDR_W-1:0] addr;
    logic              x_lo_c;
    logic              y_lo_c;
    logic              win_c;
    logic              frame_end_c;
    logic              pat_c;
    logic [23:0]       bar_rgb_c;
    pix_t              cur_c;
    pix_t              last_c;
    pix_t              dly [DEPTH];

    // Lower window bounds; a zero bound is always satisfied
    if (WIN_X == 0) begin : g_x0
        assign x_lo_c = 1'b1;
    end else begin : g_xn
        assign x_lo_c = (hc >= HC_W'(WIN_X));
    end
    if (WIN_Y == 0) begin : g_y0
        assign y_lo_c = 1'b1;
    end else begin : g_yn
        assign y_lo_c = (vc >= VC_W'(WIN_Y));
    end

`ifdef FRAME_READER_PATTERN_EN
    logic [7:1] bar_ge;
    logic [2:0] bar_idx;

    // Bar edge comparators at ceil(k*WIN_W/8) columns into the window
    for (genvar k = 1; k < 8; k++) begin : g_bar
        assign bar_ge[k] = (hc >= HC_W'(WIN_X + (k * WIN_W + 7) / 8));
    end

    // Bar index is the number of edges already passed on this line
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (bar_ge[k]) bar_idx = bar_idx + 3'd1;
        end
        bar_rgb_c = {{8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}}};
        pat_c     = pattern;
    end
`else
    assign pat_c     = 1'b0;
    assign bar_rgb_c = 24'd0;
`endif

    // Decode the current raster position into a timing payload
    always_comb begin
        win_c        = x_lo_c && (hc < HC_W'(WIN_X + WIN_W)) &&
                       y_lo_c && (vc < VC_W'(WIN_Y + WIN_H));
        frame_end_c  = (hc == HC_W'(H_TOTAL - 1)) && (vc == VC_W'(V_TOTAL - 1));
        cur_c         = PIX_IDLE;
        cur_c.hcount  = hc;
        cur_c.vcount  = vc;
        cur_c.hsync   = !((hc >= HC_W'(HS_START)) && (hc < HC_W'(HS_END)));
        cur_c.vsync   = !((vc >= VC_W'(VS_START)) && (vc < VC_W'(VS_END)));
        cur_c.blank   = (hc >= HC_W'(H_ACTIVE)) || (vc >= VC_W'(V_ACTIVE));
        cur_c.win     = win_c;
        cur_c.fstart  = (hc == '0) && (vc == '0);
        cur_c.pat     = pat_c;
        cur_c.bar_rgb = bar_rgb_c;
    end

    // Raster counters and incremental row-major window address
    always_ff @(posedge clk) begin
        if (reset) begin
            hc   <= '0;
            vc   <= '0;
            addr <= '0;
        end else begin
            if (hc == HC_W'(H_TOTAL - 1)) begin
                hc <= '0;
                vc <= (vc == VC_W'(V_TOTAL - 1)) ? '0 : vc + 10'd1;
            end else begin
                hc <= hc + 11'd1;
            end
            if (frame_end_c) addr <= '0;
            else if (win_c)  addr <= addr + ADDR_W'(1);
        end
    end

    // Stage 1: present the read request; address holds outside the window
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr <= '0;
            mem_rd   <= 1'b0;
        end else begin
            mem_rd <= win_c && !pat_c;
            if (win_c) mem_addr <= addr;
        end
    end

    // Timing delay line matching the memory read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) dly[i] <= PIX_IDLE;
        end else begin
            dly[0] <= cur_c;
            for (int unsigned i = 1; i < DEPTH; i++) dly[i] <= dly[i-1];
        end
    end

    assign last_c = dly[DEPTH-1];

    // Output register: timing and pixel data leave on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank       <= 1'b1;
            in_frame    <= 1'b0;
            rgb_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            hcount      <= last_c.hcount;
            vcount      <= last_c.vcount;
            hsync       <= last_c.hsync;
            vsync       <= last_c.vsync;
            blank       <= last_c.blank;
            in_frame    <= last_c.win;
            frame_start <= last_c.fstart;
            if (!last_c.win)     rgb_out <= '0;
            else if (last_c.pat) rgb_out <= last_c.bar_rgb;
            else                 rgb_out <= mem_data;
        end
    end

endmodule

// File: tb/tb_frame_reader.sv
// Testbench for frame_reader: two instances on a reduced raster (one full-origin
// window, one offset window with a longer memory latency), a latency-accurate memory
// model per instance and a scoreboard queue of expected output pixels.
module tb_frame_reader;

    localparam int HA = 64, HFP = 4, HS = 8, HBP = 12, HT = HA + HFP + HS + HBP;
    localparam int VA = 24, VFP = 2, VS = 3, VBP = 3, VT = VA + VFP + VS + VBP;
    localparam int AWX = 0,  AWY = 0, AWW = 40, AWH = 16, ALAT = 2, LA = ALAT + 2;
    localparam int BWX = 10, BWY = 5, BWW = 12, BWH = 6,  BLAT = 3, LB = BLAT + 2;
    localparam int NCYC = 7100;

    typedef struct packed {
        logic [10:0] hcount;
        logic [9:0]  vcount;
        logic        hsync;
        logic        vsync;
        logic        blank;
        logic        in_frame;
        logic        fstart;
        logic [23:0] rgb;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        pattern;
    logic [9:0]  mem_addr_a, mem_addr_b;
    logic        mem_rd_a, mem_rd_b;
    logic [23:0] mem_data_a, mem_data_b;
    logic [10:0] hcount_a, hcount_b;
    logic [9:0]  vcount_a, vcount_b;
    logic        hsync_a, hsync_b, vsync_a, vsync_b, blank_a, blank_b;
    logic        in_frame_a, in_frame_b, fs_a, fs_b;
    logic [23:0] rgb_a, rgb_b;

    int n_cmp = 0;
    int n_bad = 0;

    frame_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .WIN_X(AWX), .WIN_Y(AWY), .WIN_W(AWW), .WIN_H(AWH),
        .MEM_LAT(ALAT), .ADDR_W(10)
    ) dut_a (
        .clk(clk), .reset(reset),
`ifdef FRAME_READER_PATTERN_EN
        .pattern(pattern),
`endif
        .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_data(mem_data_a),
        .hcount(hcount_a), .vcount(vcount_a), .hsync(hsync_a), .vsync(vsync_a),
        .blank(blank_a), .in_frame(in_frame_a), .rgb_out(rgb_a), .frame_start(fs_a)
    );

    frame_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .WIN_X(BWX), .WIN_Y(BWY), .WIN_W(BWW), .WIN_H(BWH),
        .MEM_LAT(BLAT), .ADDR_W(10)
    ) dut_b (
        .clk(clk), .reset(reset),
`ifdef FRAME_READER_PATTERN_EN
        .pattern(pattern),
`endif
        .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_data(mem_data_b),
        .hcount(hcount_b), .vcount(vcount_b), .hsync(hsync_b), .vsync(vsync_b),
        .blank(blank_b), .in_frame(in_frame_b), .rgb_out(rgb_b), .frame_start(fs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories returning {0,addr}; a read without strobe returns junk
    logic [10:0] pipe_a [ALAT];
    logic [10:0] pipe_b [BLAT];
    always @(posedge clk) begin
        pipe_a[0] <= {mem_rd_a, mem_addr_a};
        for (int i = 1; i < ALAT; i++) pipe_a[i] <= pipe_a[i-1];
        pipe_b[0] <= {mem_rd_b, mem_addr_b};
        for (int i = 1; i < BLAT; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign mem_data_a = pipe_a[ALAT-1][10] ? 24'(pipe_a[ALAT-1][9:0]) : 24'hA5A5A5;
    assign mem_data_b = pipe_b[BLAT-1][10] ? 24'(pipe_b[BLAT-1][9:0]) : 24'hA5A5A5;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmp_pix(input string p, input exp_t got, input exp_t exp);
        check({p, ".hcount"},   got.hcount,   exp.hcount);
        check({p, ".vcount"},   got.vcount,   exp.vcount);
        check({p, ".hsync"},    got.hsync,    exp.hsync);
        check({p, ".vsync"},    got.vsync,    exp.vsync);
        check({p, ".blank"},    got.blank,    exp.blank);
        check({p, ".in_frame"}, got.in_frame, exp.in_frame);
        check({p, ".fstart"},   got.fstart,   exp.fstart);
        check({p, ".rgb"},      got.rgb,      exp.rgb);
    endtask

    function automatic bit in_win(input int id, input int hc, input int vc);
        int wx = (id == 0) ? AWX : BWX;
        int wy = (id == 0) ? AWY : BWY;
        int ww = (id == 0) ? AWW : BWW;
        int wh = (id == 0) ? AWH : BWH;
        return (hc >= wx) && (hc < wx + ww) && (vc >= wy) && (vc < wy + wh);
    endfunction

    function automatic int pix_addr(input int id, input int hc, input int vc);
        int wx = (id == 0) ? AWX : BWX;
        int wy = (id == 0) ? AWY : BWY;
        int ww = (id == 0) ? AWW : BWW;
        return (vc - wy) * ww + (hc - wx);
    endfunction

    function automatic exp_t idle_pix();
        exp_t e = '0;
        e.hsync = 1'b1;
        e.vsync = 1'b1;
        e.blank = 1'b1;
        return e;
    endfunction

    function automatic exp_t pix(input int id, input int hc, input int vc, input bit pat);
        exp_t e;
        int wx = (id == 0) ? AWX : BWX;
        int ww = (id == 0) ? AWW : BWW;
        int bi;
        bit w = in_win(id, hc, vc);
        e.hcount   = 11'(hc);
        e.vcount   = 10'(vc);
        e.hsync    = !(hc >= HA + HFP && hc < HA + HFP + HS);
        e.vsync    = !(vc >= VA + VFP && vc < VA + VFP + VS);
        e.blank    = (hc >= HA) || (vc >= VA);
        e.in_frame = w;
        e.fstart   = (hc == 0) && (vc == 0);
        if (!w) begin
            e.rgb = 24'd0;
        end else if (pat) begin
            bi    = ((hc - wx) * 8) / ww;
            e.rgb = {(bi[2] ? 8'hFF : 8'h00), (bi[1] ? 8'hFF : 8'h00), (bi[0] ? 8'hFF : 8'h00)};
        end else begin
            e.rgb = 24'(pix_addr(id, hc, vc));
        end
        return e;
    endfunction

    exp_t       qa[$];
    exp_t       qb[$];
    int         mhc, mvc, frame_no;
    bit         rst_now, mid_done;
    logic       exp_rd_a, exp_rd_b, pend_rd_a, pend_rd_b;
    logic [9:0] exp_addr_a, exp_addr_b, pend_addr_a, pend_addr_b;
    int         since, low_cnt, last_fs, n_period, n_hfall;
    bit         hs_prev, hs_fall_seen;

    initial begin
        reset = 1'b1;
        pattern = 1'b0;
        mid_done = 1'b0;
        mhc = 0; mvc = 0; frame_no = 0;
        n_period = 0; n_hfall = 0;
        pend_rd_a = 1'b0; pend_rd_b = 1'b0; pend_addr_a = '0; pend_addr_b = '0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            rst_now = reset;
            @(posedge clk);
            #1;
            if (rst_now) begin
                mhc = 0; mvc = 0; frame_no = 0;
                qa.delete(); qb.delete();
                for (int i = 0; i < LA; i++) qa.push_back(idle_pix());
                for (int i = 0; i < LB; i++) qb.push_back(idle_pix());
                exp_rd_a = 1'b0; exp_addr_a = '0;
                exp_rd_b = 1'b0; exp_addr_b = '0;
                since = 0; low_cnt = 0; last_fs = -1; hs_prev = 1'b1; hs_fall_seen = 1'b0;
            end else begin
                if (mhc == HT - 1) begin
                    mhc = 0;
                    if (mvc == VT - 1) begin
                        mvc = 0;
                        frame_no++;
                    end else begin
                        mvc++;
                    end
                end else begin
                    mhc++;
                end
                exp_rd_a = pend_rd_a; exp_addr_a = pend_addr_a;
                exp_rd_b = pend_rd_b; exp_addr_b = pend_addr_b;
                since++;
            end

            cmp_pix("a", {hcount_a, vcount_a, hsync_a, vsync_a, blank_a, in_frame_a, fs_a, rgb_a},
                    qa.pop_front());
            cmp_pix("b", {hcount_b, vcount_b, hsync_b, vsync_b, blank_b, in_frame_b, fs_b, rgb_b},
                    qb.pop_front());
            check("a.mem_rd",   mem_rd_a,   exp_rd_a);
            check("a.mem_addr", mem_addr_a, exp_addr_a);
            check("b.mem_rd",   mem_rd_b,   exp_rd_b);
            check("b.mem_addr", mem_addr_b, exp_addr_b);

            // Sync/frame timing measured on instance a relative to the last reset
            if (hs_prev && !hsync_a && !hs_fall_seen) begin
                check("a.hs_first_fall", since, HA + HFP + LA);
                hs_fall_seen = 1'b1;
                n_hfall++;
            end
            if (!hsync_a) begin
                low_cnt++;
            end else if (!hs_prev) begin
                check("a.hs_width", low_cnt, HS);
                low_cnt = 0;
            end
            hs_prev = hsync_a;
            if (fs_a) begin
                if (last_fs >= 0) begin
                    check("a.fs_period", since - last_fs, HT * VT);
                    n_period++;
                end
                last_fs = since;
            end

            // Next-edge stimulus: power-on reset, one mid-frame reset, pattern frame
            reset = (cyc < 3);
            if (!mid_done && cyc >= 3 && mhc == 50 && mvc == 12) begin
                reset = 1'b1;
                mid_done = 1'b1;
            end
`ifdef FRAME_READER_PATTERN_EN
            pattern = (frame_no == 1) &&
                      ((mvc < 10) || (mvc < 16 && $urandom_range(0, 1) == 1));
`else
            pattern = 1'b0;
`endif
            qa.push_back(pix(0, mhc, mvc, pattern));
            qb.push_back(pix(1, mhc, mvc, pattern));
            pend_rd_a   = in_win(0, mhc, mvc) && !pattern;
            pend_addr_a = in_win(0, mhc, mvc) ? 10'(pix_addr(0, mhc, mvc)) : exp_addr_a;
            pend_rd_b   = in_win(1, mhc, mvc) && !pattern;
            pend_addr_b = in_win(1, mhc, mvc) ? 10'(pix_addr(1, mhc, mvc)) : exp_addr_b;
        end
        check("mid_reset_done", mid_done, 1);
        check("a.hs_fall_seen", (n_hfall >= 2), 1);
        check("a.fs_periods", (n_period >= 2), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_reader.md
Name: frame_reader

Overview:
- Display-side pixel source feeding the video filter stage.
- Generates XGA 1024x768 raster timing and a rectangular display window.
- Fetches window pixels from a synchronous frame-buffer memory.
- Presents rgb_out, in_frame and the matching hcount/vcount/syncs, all aligned to the same pixel.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 136, hsync width (clocks)
- H_BP, 160, horizontal back porch (clocks)
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 29, vertical back porch (lines)
- WIN_X, 0, window left column
- WIN_Y, 0, window top line
- WIN_W, 640, window width (pixels)
- WIN_H, 480, window height (lines)
- MEM_LAT, 2, memory read latency in clocks (>=1)
- ADDR_W, 19, frame-buffer address width

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous active-high reset
- mem_addr  out  ADDR_W  frame-buffer read address
- mem_rd  out  1  read strobe, high for in-window pixels
- mem_data  in  24  read data {R,G,B}; valid MEM_LAT cycles after the address is presented
- hcount  out  11  pixel column of the current output
- vcount  out  10  pixel line of the current output
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- blank  out  1  high outside the active area
- in_frame  out  1  high when the output pixel is inside the window
- rgb_out  out  24  pixel data; 0 when in_frame=0
- frame_start  out  1  one-cycle pulse with output pixel (0,0)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Raster counters hc/vc: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (1344) and V_TOTAL (806).
  - hc counts 0..H_TOTAL-1, then wraps to 0 and increments vc.
  - vc wraps from V_TOTAL-1 to 0 at the same edge as the hc wrap.
- Sync and blank decode:
  - hsync low for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync low for vc in the analogous line range.
  - blank = (hc>=H_ACTIVE) | (vc>=V_ACTIVE).
- Window: win = hc in [WIN_X, WIN_X+WIN_W) and vc in [WIN_Y, WIN_Y+WIN_H).
  - Elaboration fails if WIN_X+WIN_W>H_ACTIVE, WIN_Y+WIN_H>V_ACTIVE, or WIN_W*WIN_H>2^ADDR_W.
- Address generation is incremental; no multiplier.
  - Address counter clears to 0 when hc=0, vc=0.
  - It increments by 1 after each win pixel.
  - Row-major result: addr = (vc-WIN_Y)*WIN_W + (hc-WIN_X). Last pixel = WIN_W*WIN_H-1.
- Stage 1 (registered): mem_addr <= addr, mem_rd <= win. Outside the window mem_rd=0 and mem_addr holds its last value.
- Data path and alignment:
  - Timing outputs travel through a delay line of depth MEM_LAT+1.
  - mem_data is registered into rgb_out when the delayed win is 1; otherwise rgb_out <= 0.
- Total latency L=MEM_LAT+2 clocks from internal counter to outputs. All of hcount, vcount, hsync, vsync, blank, in_frame, rgb_out and frame_start change on the same edge and describe the same pixel.
- Reset values:
  - hc=vc=0, address counter 0.
  - mem_addr=0, mem_rd=0.
  - hcount=0, vcount=0, hsync=1, vsync=1, blank=1, in_frame=0, rgb_out=0, frame_start=0.
  - Every delay-line stage is loaded with these idle values, so no spurious sync or in_frame appears during the first L cycles.
- Reset mid-frame: takes effect on the next edge irrespective of position. The raster restarts at (0,0) and the address restarts at 0.

Optional Feature:
- Macro: FRAME_READER_PATTERN_EN.
- When defined:
  - Adds input port pattern (1 bit, sampled each clock).
  - With pattern=1, in-window pixels show 8 colour bars instead of memory data.
  - Bar index i = ((hc-WIN_X)*8/WIN_W), computed by comparators on precomputed bar edges.
  - Colour: R=FF if i[2], G=FF if i[1], B=FF if i[0]; each channel is 00 otherwise.
  - mem_rd is forced to 0 while pattern=1, but the address counter still advances.
  - Latency L is unchanged.
- When undefined: the pattern port is absent and behaviour is exactly as above.

Test Plan:
- Reset release, defaults:
  - hsync=1, vsync=1, blank=1, in_frame=0 for cycles 0..L-1.
  - First hsync falling edge at cycle 1048+L (L=4 at MEM_LAT=2); it lasts 136 cycles.
  - frame_start pulses every 1344*806 cycles.
- Address sequence, default window:
  - mem_addr=0..639 on line 0 and 640 at line 1 first pixel.
  - Final address 307199; 0 again at the next frame.
  - mem_rd low for hc>=640 or vc>=480.
- Alignment: memory model returns {5'b0,addr} after 2 cycles → at every output with in_frame=1, rgb_out = vcount*640+hcount.
- Window offset WIN_X=100, WIN_Y=50, WIN_W=64, WIN_H=32:
  - in_frame first high at hcount=100, vcount=50.
  - rgb_out=0 at hcount 99 and 164; last in_frame at (163,81).
- Mid-frame reset: 1-cycle reset at hc=500, vc=300 → next cycle all outputs at reset values; mem_addr=0; raster restarts at (0,0).
- FRAME_READER_PATTERN_EN, pattern=1, default window:
  - rgb_out=000000 for hcount 0..79, 0000FF for 80..159, FFFFFF for 560..639.
  - mem_rd stays 0.
